// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake into the boot loader.
//   in_valid  producer has a byte on in_data
//   in_data   8-bit stream byte
//   in_ready  loader accepts the byte at this clock edge
// Modports: master = byte producer, slave = loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the single-cycle core.
// Takes a little-endian byte stream (4-byte word count N, then N words,
// then an optional 4-byte checksum trailer), writes the words to imem at
// addresses 0..N-1 and holds the core in reset until the image is loaded.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stream        imem_loader_if.slave byte handshake (in_valid/in_data/in_ready)
//   imem_we       one-cycle write strobe to imem
//   imem_addr     word address of the write
//   imem_wdata    word to write
//   core_rst      core reset, released one cycle after done rises
//   done          image loaded (sticky until rst)
//   error         bad image (sticky until rst)
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailer equal
// to the mod-2^32 sum of all data words.
module imem_loader #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    imem_loader_if.slave       stream,
    output logic               imem_we,
    output logic [AWIDTH-1:0]  imem_addr,
    output logic [DWIDTH-1:0]  imem_wdata,
    output logic               core_rst,
    output logic               done,
    output logic               error
);
    localparam logic [32:0] MAX_WORDS = 33'd1 << AWIDTH;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [1:0]         byte_cnt;
    logic [23:0]        shreg;      // first three bytes of the current word
    logic [AWIDTH-1:0]  word_idx;
    logic [AWIDTH:0]    n_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]        sum;
`endif

    logic               accept;
    logic               last_byte;
    logic               last_word;
    logic [31:0]        word;

    always_comb begin
        accept    = stream.in_valid & stream.in_ready;
        last_byte = (byte_cnt == 2'd3);
        // Bytes arrive LSB first, so the byte on the bus completes the word.
        word      = {stream.in_data, shreg};
        last_word = (({1'b0, word_idx} + (AWIDTH+1)'(1)) == n_words);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_HDR;
            byte_cnt        <= '0;
            shreg           <= '0;
            word_idx        <= '0;
            n_words         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum             <= '0;
`endif
            stream.in_ready <= 1'b1;
            imem_we         <= 1'b0;
            imem_addr       <= '0;
            imem_wdata      <= '0;
            core_rst        <= 1'b1;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // Release the core one cycle after done, so the last write lands first.
            if (state == S_DONE) core_rst <= 1'b0;

            if (accept) begin
                shreg    <= word[31:8];
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    case (state)
                        S_HDR: begin
                            if ({1'b0, word} > MAX_WORDS) begin
                                state           <= S_ERR;
                                stream.in_ready <= 1'b0;
                                error           <= 1'b1;
                            end else if (word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state           <= S_CSUM;
`else
                                state           <= S_DONE;
                                stream.in_ready <= 1'b0;
                                done            <= 1'b1;
`endif
                            end else begin
                                n_words <= word[AWIDTH:0];
                                state   <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx;
                            imem_wdata <= DWIDTH'(word);
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum        <= sum + word;
`endif
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state           <= S_CSUM;
`else
                                state           <= S_DONE;
                                stream.in_ready <= 1'b0;
                                done            <= 1'b1;
`endif
                            end else begin
                                word_idx <= word_idx + AWIDTH'(1);
                            end
                        end
`ifdef IMEM_LOADER_CHECKSUM_EN
                        S_CSUM: begin
                            stream.in_ready <= 1'b0;
                            if (word == sum) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_ERR;
                                error <= 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: images are built from a word list,
// expected imem writes are queued at issue time and checked by a monitor.
module tb_imem_loader;
    localparam int unsigned AW = 10;
    localparam logic [32:0] MAXW = 33'd1 << AW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           imem_we;
    logic [AW-1:0]  imem_addr;
    logic [31:0]    imem_wdata;
    logic           core_rst;
    logic           done;
    logic           error;

    imem_loader_if stream();

    imem_loader #(.DWIDTH(32), .AWIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stream     (stream),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t          exp_q[$];
    logic [31:0]  img_words[$];
    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    logic         prev_we  = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endfunction

    // Monitor: every write strobe must match the next queued write.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write actual=%0h@%0h required=none", imem_wdata, imem_addr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {54'd0, imem_addr}, {54'd0, e.a});
                    chk("wr_data", {32'd0, imem_wdata}, {32'd0, e.d});
                end
            end
            prev_we = imem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        stream.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        bit r;
        int unsigned cyc = 0;
        stream.in_valid = 1'b1;
        stream.in_data  = b;
        while (!ok && cyc < 50) begin
            r = stream.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (r) ok = 1;
        end
        stream.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
    endtask

    // Reference: header N; if N fits, all words are written in order and the
    // load succeeds (with checksum: only if the trailer equals the word sum).
    task automatic run_image(input logic [31:0] n_hdr, input logic [31:0] delta,
                             input int unsigned glo, input int unsigned ghi);
        logic [7:0]  bytes[$];
        logic [31:0] sum = '0;
        logic [31:0] w;
        bit          ok_exp;
        bit          oversize = ({1'b0, n_hdr} > MAXW);
        int unsigned g;
        for (int k = 0; k < 4; k++) bytes.push_back(8'(n_hdr >> (8*k)));
        if (!oversize) begin
            for (int i = 0; i < img_words.size(); i++) begin
                w = img_words[i];
                for (int k = 0; k < 4; k++) bytes.push_back(8'(w >> (8*k)));
                sum += w;
                exp_q.push_back('{a: AW'(i), d: w});
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            w = sum + delta;
            for (int k = 0; k < 4; k++) bytes.push_back(8'(w >> (8*k)));
            ok_exp = (delta == 0);
`else
            ok_exp = 1;
`endif
        end else begin
            ok_exp = 0;
        end
        for (int i = 0; i < bytes.size(); i++) begin
            if (i > 0) begin
                g = $urandom_range(ghi, glo);
                repeat (g) begin
                    chk("in_ready_gap", {63'd0, stream.in_ready}, 64'd1);
                    @(posedge clk); #1;
                end
            end
            chk("in_ready_byte", {63'd0, stream.in_ready}, 64'd1);
            send_byte(bytes[i]);
        end
        chk("done_after_last", {63'd0, done}, {63'd0, ok_exp});
        chk("error_after_last", {63'd0, error}, {63'd0, !ok_exp});
        chk("ready_low_end", {63'd0, stream.in_ready}, 64'd0);
        chk("core_rst_still_high", {63'd0, core_rst}, 64'd1);
        @(posedge clk); #1;
        chk("core_rst_final", {63'd0, core_rst}, {63'd0, !ok_exp});
        repeat (3) @(posedge clk);
        #1;
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic basic_words();
        img_words.delete();
        img_words.push_back(32'h11223344);
        img_words.push_back(32'h55667788);
        img_words.push_back(32'h99AABBCC);
    endtask

    initial begin
        int unsigned n;
        logic [31:0] d;
        stream.in_valid = 1'b0;
        stream.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, stream.in_ready}, 64'd1);
        chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
        chk("rst_imem_addr", {54'd0, imem_addr}, 64'd0);
        chk("rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
        chk("rst_core_rst", {63'd0, core_rst}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        rst = 1'b0;

        basic_words();
        run_image(32'd3, 32'd0, 0, 0);
        do_reset();
        run_image(32'd3, 32'd0, 3, 3);
        do_reset();

        img_words.delete();
        run_image(32'd0, 32'd0, 0, 0);
        do_reset();

        run_image(32'h401, 32'd0, 0, 0);
        stream.in_valid = 1'b1;
        stream.in_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        stream.in_valid = 1'b0;
        chk("err_sticky", {63'd0, error}, 64'd1);
        chk("err_ready_low", {63'd0, stream.in_ready}, 64'd0);
        chk("err_core_rst", {63'd0, core_rst}, 64'd1);
        do_reset();

        run_image(32'hFFFF_FFFF, 32'd0, 0, 0);
        do_reset();

        img_words.delete();
        for (int i = 0; i < 1024; i++) img_words.push_back($urandom);
        run_image(32'd1024, 32'd0, 0, 0);
        do_reset();

`ifdef IMEM_LOADER_CHECKSUM_EN
        img_words.delete();
        img_words.push_back(32'h0000_0001);
        img_words.push_back(32'hFFFF_FFFF);
        run_image(32'd2, 32'd0, 0, 0);
        do_reset();
        run_image(32'd2, 32'd1, 0, 0);
        do_reset();
`endif

        basic_words();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h44); send_byte(8'h33);
        do_reset();
        chk("midrst_ready", {63'd0, stream.in_ready}, 64'd1);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_core_rst", {63'd0, core_rst}, 64'd1);
        run_image(32'd3, 32'd0, 0, 0);
        do_reset();

        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(12, 1);
            img_words.delete();
            for (int i = 0; i < n; i++) img_words.push_back($urandom);
            d = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ($urandom_range(2, 0) == 0) d = $urandom | 32'd1;
`endif
            run_image(n, d, 0, $urandom_range(2, 0));
            do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle core and its instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into the instruction memory's write port. It holds the core in reset until the whole image is written. It then releases the core so fetch starts at PC 0 with the loaded program.

## Interface
- `DWIDTH`, 32: instruction word width. Only 32 is supported.
- `AWIDTH`, 10: instruction memory word-address width. `MAX_WORDS = 2**AWIDTH`.

- `clk`  in  1  clock
- `rst`  in  1  reset; rst, synchronous, active-high; clock clk
- `in_valid`  in  1  byte present on `in_data`
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader accepts a byte this cycle
- `imem_we`  out  1  one-cycle write strobe to imem
- `imem_addr`  out  AWIDTH  word address of the write
- `imem_wdata`  out  DWIDTH  word to write
- `core_rst`  out  1  reset to the core; high until the load completes
- `done`  out  1  image loaded; sticky until `rst`
- `error`  out  1  bad image; sticky until `rst`

## Operation
- **Byte acceptance:** a byte is accepted at a rising edge where `in_valid & in_ready` is high. Nothing else advances the stream.
- **Stream format:**
  - First, a 4-byte header giving word count N, LSB first.
  - Then N words of 4 bytes each, LSB first.
  - Then, only when `IMEM_LOADER_CHECKSUM_EN` is defined, a 4-byte trailer, LSB first.
- **States:**
  - HDR: shift header bytes in.
  - DATA: assemble words.
  - CSUM: compare the trailer.
  - DONE.
  - ERR.
- **`in_ready`:** 1 in HDR, DATA and CSUM; 0 in DONE and ERR.
- **HDR → next state,** decided on the 4th header byte:
  - N > MAX_WORDS → ERR.
  - N == 0 → DONE, or CSUM if the checksum feature is compiled in.
  - Otherwise → DATA.
- **Word assembly:** a 2-bit byte counter tracks the byte position. On the 4th byte of a word, the following are registered:
  - `imem_we=1`
  - `imem_addr` = word index
  - `imem_wdata` = assembled word
  
  The word index then increments. The index starts at 0 and never wraps, because N ≤ MAX_WORDS is enforced.
- **DATA exit:** after word N-1, go to DONE, or to CSUM if the checksum feature is compiled in.
- **CSUM:** on the 4th trailer byte, compare the trailer with the running sum.
  - Equal → DONE.
  - Different → ERR.
- **DONE:** `done=1`, `core_rst=0`.
- **ERR:** `error=1`, `core_rst=1`.
- Only `rst` leaves DONE or ERR. Extra input bytes in those states are not accepted.
- **Reset values:**
  - State: HDR.
  - Counters and checksum: 0.
  - `in_ready=1`.
  - `imem_we=0`, `imem_addr=0`, `imem_wdata=0`.
  - `core_rst=1`, `done=0`, `error=0`.
- **Reset mid-load:** restart at HDR. Partially assembled bytes are discarded. Words already written stay in imem and are overwritten by the next load.

## Timing
- **Write latency:** the accept edge of a word's 4th byte is edge E. `imem_we` is high in the cycle after E, for exactly one cycle. Addr and data are valid in that same cycle. The imem captures the word at edge E+1.
- **Throughput:** one byte per cycle with no bubbles. `in_ready` never drops while the loader is in HDR, DATA or CSUM.
- **Completion:**
  - `done` rises in the cycle after the accept edge of the final byte. That is the same cycle as the last `imem_we` when there is no checksum.
  - `core_rst` falls one cycle later. The core's first fetch therefore sees all words written.
- **Error:** `error` rises in the cycle after the accept edge of the offending byte. No `imem_we` pulse is issued for an oversize header.
- **Gaps in `in_valid`:** these stall all state, counters and outputs; `imem_we` stays 0 during them.

## Configuration
- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - A 32-bit running sum (mod 2^32) of all data words is kept.
  - The CSUM state and the 4-byte trailer are present.
  - A mismatch goes to ERR.
  - With N == 0, the trailer must be 0x00000000.
- **Not defined:**
  - No sum register and no CSUM state.
  - The image ends after the last data byte.
  - ERR is reachable only through an oversize header.

## Test plan
- **Basic load (macro off):** bytes `03 00 00 00`, `44 33 22 11`, `88 77 66 55`, `CC BB AA 99`. Required response:
  - Three `imem_we` pulses, writing 0x11223344@0, 0x55667788@1 and 0x99AABBCC@2.
  - `done=1`.
  - `core_rst` falls one cycle after the last pulse.
- **Valid gaps:** same image as the basic load, with `in_valid` low for 3 cycles between every byte. Required response: identical writes and values, no extra `imem_we` pulses, and `in_ready` constantly 1 until DONE.
- **Empty image:** N=0 (macro off). Required response: no writes, and `done=1` in the cycle after the 4th header byte.
- **Oversize header:** AWIDTH=10, N=0x401. Required response: `error=1` after the 4th header byte, `in_ready=0`, no writes, and `core_rst` stays 1.
- **Checksum (macro on):** N=2 with words 0x00000001 and 0xFFFFFFFF.
  - Trailer `00 00 00 00` → `done=1`.
  - Trailer `01 00 00 00` → `error=1` and `core_rst=1`. Both words are still written.
- **Reset mid-load:** assert `rst` after 6 accepted bytes of the basic-load image, then resend the full image. Required response: exactly three writes, at addresses 0, 1 and 2, followed by `done=1`.
